multicycle_controller: RTL and testbench

- Multi-cycle control FSM that sequences the shared RISC-V datapath: one ALU, one unified instruction/data memory port, and the register file.
- Each instruction is issued over 3-5 states. Per state, the FSM drives PC/IR write enables, operand and result mux selects, memory request/write, and register write.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
- Handles memory wait states and traps on illegal opcodes or memory timeout.

---
 rtl/multicycle_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multi-cycle RISC-V control FSM that sequences a shared ALU,
//            a unified memory port and the register file, with wait-state
//            timeout and illegal-opcode traps.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int MEM_WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic [1:0] fault,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECR    = 4'd6;
    localparam logic [3:0] c_EXECI    = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BEQ      = 4'd9;
    localparam logic [3:0] c_JAL      = 4'd10;
    localparam logic [3:0] c_TRAP     = 4'd15;

    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_SLT  = 3'b100;

    localparam logic [1:0] c_FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] c_FAULT_TIMEOUT = 2'b10;

    localparam logic [7:0] c_WAIT_LIMIT = 8'(MEM_WAIT_LIMIT);
    localparam bit         c_TIMEOUT_EN = (MEM_WAIT_LIMIT != 0);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [7:0] r_wait_cnt;
    logic [1:0] r_fault;
    logic       w_fault_set;
    logic [1:0] w_fault_code;
    logic       w_mem_wait;
    logic       w_timeout;
    logic [2:0] w_alu_decoded;

    assign w_mem_wait = ((r_state == c_FETCH) || (r_state == c_MEMREAD) ||
                         (r_state == c_MEMWRITE)) && !mem_ready;
    // The limit is reached on the cycle that would make the count equal it,
    // so exactly MEM_WAIT_LIMIT request cycles are issued before the trap.
    assign w_timeout  = c_TIMEOUT_EN && w_mem_wait &&
                        (({1'b0, r_wait_cnt} + 9'd1) == {1'b0, c_WAIT_LIMIT});

    assign state_dbg  = r_state;
    assign fault      = r_fault;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_FETCH;
            r_fault    <= 2'b00;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (w_fault_set) begin
                r_fault <= w_fault_code;
            end
            if (w_mem_wait && (w_next_state == r_state)) begin
                if (r_wait_cnt != 8'hFF) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end else begin
                r_wait_cnt <= 8'd0;
            end
        end
    end

    always_comb begin
        w_alu_decoded = c_ALU_ADD;
        case (funct3)
            3'b000:  if ((r_state == c_EXECR) && funct7b5) w_alu_decoded = c_ALU_SUB;
            3'b010:  w_alu_decoded = c_ALU_SLT;
            3'b110:  w_alu_decoded = c_ALU_OR;
            3'b111:  w_alu_decoded = c_ALU_AND;
            default: w_alu_decoded = c_ALU_ADD;
        endcase
    end

    always_comb begin
        case (op)
            c_OP_SW:  imm_src = 2'b01;
            c_OP_BEQ: imm_src = 2'b10;
            c_OP_JAL: imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_fault_set  = 1'b0;
        w_fault_code = 2'b00;
        pc_write     = 1'b0;
        adr_src      = 1'b0;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        reg_write    = 1'b0;
        alu_control  = c_ALU_ADD;

        case (r_state)
            c_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_next_state = c_DECODE;
                end else if (w_timeout) begin
                    w_next_state = c_TRAP;
                    w_fault_set  = 1'b1;
                    w_fault_code = c_FAULT_TIMEOUT;
                end
            end
            c_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    c_OP_LW, c_OP_SW: w_next_state = c_MEMADR;
                    c_OP_R:           w_next_state = c_EXECR;
                    c_OP_I:           w_next_state = c_EXECI;
                    c_OP_BEQ:         w_next_state = c_BEQ;
                    c_OP_JAL:         w_next_state = c_JAL;
                    default: begin
                        w_next_state = c_TRAP;
                        w_fault_set  = 1'b1;
                        w_fault_code = c_FAULT_ILLEGAL;
                    end
                endcase
            end
            c_MEMADR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                w_next_state = (op == c_OP_LW) ? c_MEMREAD : c_MEMWRITE;
            end
            c_MEMREAD, c_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = (r_state == c_MEMWRITE);
                if (mem_ready) begin
                    w_next_state = (r_state == c_MEMREAD) ? c_MEMWB : c_FETCH;
                end else if (w_timeout) begin
                    w_next_state = c_TRAP;
                    w_fault_set  = 1'b1;
                    w_fault_code = c_FAULT_TIMEOUT;
                end
            end
            c_MEMWB: begin
                result_src   = 2'b01;
                reg_write    = 1'b1;
                w_next_state = c_FETCH;
            end
            c_EXECR, c_EXECI: begin
                alu_src_a    = 2'b10;
                alu_src_b    = (r_state == c_EXECI) ? 2'b01 : 2'b00;
                alu_control  = w_alu_decoded;
                w_next_state = c_ALUWB;
            end
            c_ALUWB: begin
                reg_write    = 1'b1;
                w_next_state = c_FETCH;
            end
            c_BEQ: begin
                alu_src_a    = 2'b10;
                alu_control  = c_ALU_SUB;
                pc_write     = zero;
                w_next_state = c_FETCH;
            end
            c_JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                pc_write     = 1'b1;
                w_next_state = c_ALUWB;
            end
            c_TRAP: begin
                w_next_state = c_TRAP;
            end
            default: begin
                w_next_state = c_TRAP;
            end
        endcase

        // Reset aborts immediately: no write of any kind leaves this cycle.
        if (!reset) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            mem_req     = 1'b0;
            mem_write   = 1'b0;
            adr_src     = 1'b0;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b10;
            result_src  = 2'b10;
            alu_control = c_ALU_ADD;
            w_fault_set = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed self-checking bench for multicycle_controller with a
//            per-cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, fault;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    multicycle_controller #(.MEM_WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .imm_src(imm_src), .alu_control(alu_control),
        .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_state = 0;
    int         m_wait  = 0;
    int         m_nxt;
    logic [1:0] m_fault = 2'b00;

    function automatic int after_decode(input logic [6:0] o);
        case (o)
            7'b0000011, 7'b0100011: return 2;
            7'b0110011:             return 6;
            7'b0010011:             return 7;
            7'b1100011:             return 9;
            7'b1101111:             return 10;
            default:                return 15;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_state = 0;
            m_wait  = 0;
            m_fault = 2'b00;
        end else begin
            m_nxt = m_state;
            if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
                m_wait++;
                if (LIMIT != 0 && m_wait == LIMIT) begin
                    m_nxt   = 15;
                    m_fault = 2'b10;
                end
            end else begin
                case (m_state)
                    0:  m_nxt = 1;
                    1: begin
                        m_nxt = after_decode(op);
                        if (m_nxt == 15) m_fault = 2'b01;
                    end
                    2:  m_nxt = (op == 7'b0000011) ? 3 : 5;
                    3:  m_nxt = 4;
                    5:  m_nxt = 0;
                    6, 7, 10: m_nxt = (m_state == 10) ? 8 : 8;
                    15: m_nxt = 15;
                    default: m_nxt = 0;
                endcase
            end
            if (m_nxt != m_state) m_wait = 0;
            m_state = m_nxt;
        end
    end

    // {pc_write, adr_src, mem_req, mem_write, ir_write, result_src, alu_src_a, alu_src_b, reg_write}
    function automatic logic [11:0] exp_ctrl(input int st, input logic rst_n,
                                             input logic rdy, input logic z);
        logic [11:0] t;
        case (st)
            0:  t = 12'b0_0_1_0_0_10_00_10_0;
            1:  t = 12'b0_0_0_0_0_00_01_01_0;
            2:  t = 12'b0_0_0_0_0_00_10_01_0;
            3:  t = 12'b0_1_1_0_0_00_00_00_0;
            4:  t = 12'b0_0_0_0_0_01_00_00_1;
            5:  t = 12'b0_1_1_1_0_00_00_00_0;
            6:  t = 12'b0_0_0_0_0_00_10_00_0;
            7:  t = 12'b0_0_0_0_0_00_10_01_0;
            8:  t = 12'b0_0_0_0_0_00_00_00_1;
            9:  t = 12'b0_0_0_0_0_00_10_00_0;
            10: t = 12'b1_0_0_0_0_00_01_10_0;
            default: t = 12'b0;
        endcase
        if (st == 0 && rdy) begin
            t[11] = 1'b1;
            t[7]  = 1'b1;
        end
        if (st == 9) t[11] = z;
        if (!rst_n) t = 12'b0_0_0_0_0_10_00_10_0;
        return t;
    endfunction

    function automatic logic [2:0] exp_alu(input int st, input logic rst_n,
                                           input logic [2:0] f3, input logic f7);
        if (!rst_n) return 3'd0;
        if (st == 9) return 3'd1;
        if (st != 6 && st != 7) return 3'd0;
        case (f3)
            3'd0:    return (st == 6 && f7) ? 3'd1 : 3'd0;
            3'd2:    return 3'd4;
            3'd6:    return 3'd3;
            3'd7:    return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_ctrl", {pc_write, adr_src, mem_req, mem_write, ir_write,
                               result_src, alu_src_a, alu_src_b, reg_write},
                exp_ctrl(m_state, reset, mem_ready, zero));
            chk("model_alu", alu_control, exp_alu(m_state, reset, funct3, funct7b5));
            chk("model_imm", imm_src, exp_imm(op));
            chk("model_state", state_dbg, m_state);
            chk("model_fault", fault, m_fault);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input string name, input int st);
        #2;
        chk(name, state_dbg, st);
    endtask

    logic [2:0] f3_tab [4] = '{3'd2, 3'd6, 3'd7, 3'd3};
    logic [2:0] alu_tab[4] = '{3'd4, 3'd3, 3'd2, 3'd0};

    initial begin
        reset = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0;
        tick();
        cmp_en = 1'b1;
        at("reset_state", 0);
        chk("reset_fault", fault, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_ir_write", ir_write, 0);
        chk("reset_alu_src_b", alu_src_b, 2);
        tick();
        reset = 1'b1;

        // addi x1,x0,5 (funct7b5 set to prove it is ignored for I-type)
        op = 7'b0010011; funct3 = 3'd0; funct7b5 = 1'b1; mem_ready = 1'b1;
        at("addi_fetch", 0);
        chk("addi_ir_write", ir_write, 1);
        chk("addi_pc_write", pc_write, 1);
        tick();
        at("addi_decode", 1); tick();
        at("addi_execi", 7);
        chk("addi_alu", alu_control, 0);
        chk("addi_imm", imm_src, 0);
        tick();
        at("addi_aluwb", 8);
        chk("addi_reg_write", reg_write, 1);
        tick();

        // lw with two wait cycles in MEMREAD
        op = 7'b0000011;
        at("lw_fetch", 0); tick();
        at("lw_decode", 1); tick();
        at("lw_memadr", 2); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1'b1;
            at("lw_memread", 3);
            chk("lw_mem_req", mem_req, 1);
            chk("lw_adr_src", adr_src, 1);
            tick();
        end
        at("lw_memwb", 4);
        chk("lw_reg_write", reg_write, 1);
        chk("lw_result_src", result_src, 1);
        tick();

        // beq taken then not taken
        op = 7'b1100011;
        for (int zi = 0; zi < 2; zi++) begin
            at("beq_fetch", 0); tick();
            at("beq_decode", 1); tick();
            zero = (zi == 0);
            at("beq_state", 9);
            chk("beq_pc_write", pc_write, (zi == 0) ? 1 : 0);
            chk("beq_alu", alu_control, 1);
            tick();
            zero = 1'b0;
        end

        // R-type sub, with three fetch wait cycles below the timeout limit
        op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at("r_fetch_wait", 0);
            chk("r_fetch_req", mem_req, 1);
            tick();
        end
        mem_ready = 1'b1;
        at("r_fetch_ready", 0); tick();
        at("r_decode", 1); tick();
        at("r_execr", 6);
        chk("r_sub_alu", alu_control, 1);
        tick();
        at("r_aluwb", 8); tick();

        // remaining R-type ALU decodes
        funct7b5 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            funct3 = f3_tab[k];
            at("rk_fetch", 0); tick();
            at("rk_decode", 1); tick();
            at("rk_execr", 6);
            chk("rk_alu", alu_control, alu_tab[k]);
            tick();
            at("rk_aluwb", 8); tick();
        end

        // sw with three wait cycles in MEMWRITE
        op = 7'b0100011; funct3 = 3'd2;
        at("sw_fetch", 0); tick();
        at("sw_decode", 1); tick();
        at("sw_memadr", 2);
        chk("sw_imm", imm_src, 1);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            at("sw_memwrite", 5);
            chk("sw_mem_write", mem_write, 1);
            tick();
        end

        // jal
        op = 7'b1101111;
        at("jal_fetch", 0); tick();
        at("jal_decode", 1); tick();
        at("jal_state", 10);
        chk("jal_pc_write", pc_write, 1);
        chk("jal_imm", imm_src, 3);
        tick();
        at("jal_aluwb", 8); tick();

        // reset asserted during MEMWRITE
        op = 7'b0100011;
        at("swr_fetch", 0); tick();
        at("swr_decode", 1); tick();
        at("swr_memadr", 2); tick();
        mem_ready = 1'b0;
        at("swr_memwrite", 5); tick();
        reset = 1'b0;
        at("swr_reset_cycle", 5);
        chk("swr_mem_write", mem_write, 0);
        chk("swr_mem_req", mem_req, 0);
        tick();
        reset = 1'b1;

        // fetch timeout: mem_ready held low
        for (int i = 0; i < LIMIT; i++) begin
            at("to_fetch", 0);
            chk("to_mem_req", mem_req, 1);
            tick();
        end
        at("to_trap", 15);
        chk("to_fault", fault, 2);
        chk("to_mem_req_drop", mem_req, 0);
        tick();
        reset = 1'b0; tick(); reset = 1'b1;

        // illegal opcode
        op = 7'b1111111; mem_ready = 1'b1;
        at("ill_fetch", 0); tick();
        at("ill_decode", 1); tick();
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            at("ill_trap", 15);
            chk("ill_fault", fault, 1);
            chk("ill_enables", {pc_write, ir_write, reg_write, mem_req, mem_write}, 0);
            tick();
        end
        reset = 1'b0;
        at("ill_reset_cycle", 15);
        tick();
        reset = 1'b1;
        at("ill_post_reset", 0);
        chk("ill_post_fault", fault, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
